fir_tx_param: RTL and testbench

Parametrised transposed-form FIR filter: the successor to the fixed 19-tap, 16-bit pipelined FIR in the filter datapath. Tap count, data, coefficient and output widths, output scaling, and rounding mode are all parameters. Coefficients are run-time programmable through a double-buffered (shadow/active) bank, and samples enter under a valid qualifier. The output stage rounds and saturates, and flags overflow. The block sits between the sample source and the downstream decimator/recorder, one sample per accepted `in_valid`.

---
 rtl/fir_tx_param_if.sv | 31 +++
 rtl/fir_tx_param.sv | 120 ++++++++++++
 tb/tb_fir_tx_param.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_tx_param_if.sv
// Sample, coefficient-programming and filtered-output signals of fir_tx_param.
// The master side feeds samples and coefficients; the slave side is the filter.
interface fir_tx_param_if #(
    parameter int TAPS   = 19,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16
);
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

    logic signed [DATA_W-1:0] data_in;
    logic                     in_valid;
    logic                     flush;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     coef_swap;
    logic signed [OUT_W-1:0]  data_out;
    logic                     out_valid;
    logic                     ovf;

    modport master (
        output data_in, in_valid, flush, coef_we, coef_addr, coef_data, coef_swap,
        input  data_out, out_valid, ovf
    );

    modport slave (
        input  data_in, in_valid, flush, coef_we, coef_addr, coef_data, coef_swap,
        output data_out, out_valid, ovf
    );
endinterface

// File: rtl/fir_tx_param.sv
// Parametrised transposed-form FIR with shadow/active coefficient banks,
// valid-qualified sample chain, and a rounding/saturating output register.
module fir_tx_param #(
    parameter int TAPS      = 19,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 19,
    parameter int ROUND     = 1
) (
    input logic           clk,
    input logic           reset,
    fir_tx_param_if.slave bus
);
    localparam int AW      = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int ACC_W   = DATA_W + COEF_W + $clog2(TAPS);
    // One guard bit so the rounding add can never wrap.
    localparam int SUM_W   = ACC_W + 1;
    localparam int RND_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [SUM_W-1:0] RND_ADD =
        (ROUND != 0 && OUT_SHIFT > 0) ? (SUM_W'(1) << RND_POS) : '0;
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] prod_w   [TAPS];
    logic signed [ACC_W-1:0] acc_reg  [TAPS];
    logic signed [ACC_W-1:0] acc_next [TAPS];
    logic                    pend_reg;
    logic signed [SUM_W-1:0] sum_w;
    logic signed [SUM_W-1:0] shr_w;
    logic                    sat_hi;
    logic                    sat_lo;
    logic signed [OUT_W-1:0] data_out_reg;
    logic                    out_valid_reg;
    logic                    ovf_reg;

    assign x_ext = $signed({{(ACC_W - DATA_W){bus.data_in[DATA_W-1]}}, bus.data_in});

    // Per-coefficient storage: prod_w[k] = a[k] * x using the active bank.
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef
        logic signed [COEF_W-1:0] shadow_reg;
        logic signed [COEF_W-1:0] active_reg;
        logic signed [ACC_W-1:0]  coef_ext;

        // Swap copies the pre-write shadow; flush leaves both banks alone.
        always_ff @(posedge clk) begin
            if (reset) begin
                shadow_reg <= '0;
                active_reg <= '0;
            end else begin
                if (bus.coef_swap)
                    active_reg <= shadow_reg;
                if (bus.coef_we && bus.coef_addr == AW'(gi))
                    shadow_reg <= bus.coef_data;
            end
        end

        assign coef_ext   = $signed({{(ACC_W - COEF_W){active_reg[COEF_W-1]}}, active_reg});
        assign prod_w[gi] = coef_ext * x_ext;
    end

    // Transposed chain: stage i adds the product for coefficient TAPS-1-i.
    always_comb begin
        acc_next[0] = prod_w[TAPS-1];
        for (int i = 1; i < TAPS; i++)
            acc_next[i] = acc_reg[i-1] + prod_w[TAPS-1-i];
    end

    // Chain advances only on accepted samples; flush drops the sample and the pending output.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            for (int i = 0; i < TAPS; i++)
                acc_reg[i] <= '0;
            pend_reg <= 1'b0;
        end else begin
            pend_reg <= bus.in_valid;
            if (bus.in_valid) begin
                for (int i = 0; i < TAPS; i++)
                    acc_reg[i] <= acc_next[i];
            end
        end
    end

    assign sum_w  = $signed({acc_reg[TAPS-1][ACC_W-1], acc_reg[TAPS-1]}) + RND_ADD;
    assign shr_w  = sum_w >>> OUT_SHIFT;
    assign sat_hi = (shr_w > SAT_MAX);
    assign sat_lo = (shr_w < SAT_MIN);

    // Output register: round, shift and clamp the chain tail one edge after acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_reg  <= '0;
            out_valid_reg <= 1'b0;
            ovf_reg       <= 1'b0;
        end else if (bus.flush) begin
            out_valid_reg <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            out_valid_reg <= pend_reg;
            ovf_reg       <= pend_reg && (sat_hi || sat_lo);
            if (pend_reg) begin
                if (sat_hi)
                    data_out_reg <= OUT_MAX;
                else if (sat_lo)
                    data_out_reg <= OUT_MIN;
                else
                    data_out_reg <= shr_w[OUT_W-1:0];
            end
        end
    end

    assign bus.data_out  = data_out_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_fir_tx_param.sv
// Bench for fir_tx_param: three instances (shift 0 truncate, shift 1 round,
// shift 1 truncate) share one stimulus stream; a direct-form convolution model
// feeds per-instance expectation queues that a negedge monitor drains.
module tb_fir_tx_param;
    localparam int TAPS = 19;
    localparam int NDUT = 3;

    typedef struct packed {
        logic signed [15:0] data;
        logic               ovf;
        int                 due;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic               flush = 1'b0;
    logic               coef_we = 1'b0;
    logic               coef_swap = 1'b0;
    logic signed [15:0] data_in = '0;
    logic signed [15:0] coef_data = '0;
    logic [4:0]         coef_addr = '0;

    logic signed [15:0] dout_w [NDUT];
    logic               oval_w [NDUT];
    logic               ovf_w  [NDUT];

    exp_t   sbq [NDUT][$];
    int     edge_cnt = 0;
    int     cancel_edge = -1;
    int     reset_edge = -1;
    int     errors = 0;
    int     checks = 0;
    logic signed [15:0] last_out [NDUT];

    // Reference state: coefficient banks and history of accepted samples,
    // each sample tagged with the active bank in force when it was accepted.
    longint shadow [TAPS];
    longint active [TAPS];
    longint hist_x [TAPS];
    longint hist_c [TAPS][TAPS];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int SHIFT = (gi == 0) ? 0 : 1;
        localparam int RND   = (gi == 1) ? 1 : 0;

        fir_tx_param_if #(.TAPS(TAPS), .DATA_W(16), .COEF_W(16), .OUT_W(16)) bus ();

        assign bus.data_in   = data_in;
        assign bus.in_valid  = in_valid;
        assign bus.flush     = flush;
        assign bus.coef_we   = coef_we;
        assign bus.coef_addr = coef_addr;
        assign bus.coef_data = coef_data;
        assign bus.coef_swap = coef_swap;

        fir_tx_param #(
            .TAPS(TAPS), .DATA_W(16), .COEF_W(16), .OUT_W(16),
            .OUT_SHIFT(SHIFT), .ROUND(RND)
        ) dut (
            .clk(clk),
            .reset(reset),
            .bus(bus)
        );

        assign dout_w[gi] = bus.data_out;
        assign oval_w[gi] = bus.out_valid;
        assign ovf_w[gi]  = bus.ovf;
    end

    function automatic exp_t make_exp(longint y, int d, int due);
        int     sh;
        bit     rn;
        longint v;
        longint s;
        exp_t   e;
        sh = (d == 0) ? 0 : 1;
        rn = (d == 1);
        v = y;
        if (rn && sh > 0)
            v = v + (longint'(1) <<< (sh - 1));
        s = v >>> sh;
        e.due = due;
        e.ovf = 1'b0;
        if (s > 32767) begin
            e.data = 16'h7fff;
            e.ovf  = 1'b1;
        end else if (s < -32768) begin
            e.data = 16'h8000;
            e.ovf  = 1'b1;
        end else begin
            e.data = 16'(s);
        end
        return e;
    endfunction

    task automatic model_update();
        longint y;
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                hist_x[k] = 0;
                shadow[k] = 0;
                active[k] = 0;
            end
            cancel_edge = edge_cnt;
            reset_edge  = edge_cnt;
        end else begin
            if (flush) begin
                for (int k = 0; k < TAPS; k++)
                    hist_x[k] = 0;
                cancel_edge = edge_cnt;
            end else if (in_valid) begin
                for (int j = TAPS - 1; j > 0; j--) begin
                    hist_x[j] = hist_x[j-1];
                    for (int k = 0; k < TAPS; k++)
                        hist_c[j][k] = hist_c[j-1][k];
                end
                hist_x[0] = longint'(data_in);
                for (int k = 0; k < TAPS; k++)
                    hist_c[0][k] = active[k];
                y = 0;
                for (int k = 0; k < TAPS; k++)
                    y = y + hist_c[k][k] * hist_x[k];
                for (int d = 0; d < NDUT; d++)
                    sbq[d].push_back(make_exp(y, d, edge_cnt + 1));
            end
            if (coef_swap) begin
                for (int k = 0; k < TAPS; k++)
                    active[k] = shadow[k];
            end
            if (coef_we && int'(coef_addr) < TAPS)
                shadow[coef_addr] = longint'(coef_data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
        model_update();
        in_valid  = 1'b0;
        flush     = 1'b0;
        coef_we   = 1'b0;
        coef_swap = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic send(input int x);
        data_in  = 16'(x);
        in_valid = 1'b1;
        tick();
    endtask

    task automatic wcoef(input int k, input int c);
        coef_we   = 1'b1;
        coef_addr = 5'(k);
        coef_data = 16'(c);
        tick();
    endtask

    task automatic swap_banks();
        coef_swap = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
    endtask

    task automatic load_ramp();
        for (int k = 0; k < TAPS; k++)
            wcoef(k, k + 1);
    endtask

    // Monitor: compare every presented output against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (edge_cnt > 0) begin
            for (int d = 0; d < NDUT; d++) begin
                if (cancel_edge == edge_cnt) begin
                    while (sbq[d].size() > 0 && sbq[d][0].due <= edge_cnt)
                        void'(sbq[d].pop_front());
                end
                if (reset_edge == edge_cnt) begin
                    checks++;
                    last_out[d] = '0;
                    if (oval_w[d] !== 1'b0 || dout_w[d] !== 16'sd0 || ovf_w[d] !== 1'b0) begin
                        errors++;
                        $display("FAIL reset_state dut%0d edge %0d: got valid=%b data=%0d ovf=%b, want 0 0 0",
                                 d, edge_cnt, oval_w[d], dout_w[d], ovf_w[d]);
                    end
                end else if (oval_w[d] === 1'b1) begin
                    checks++;
                    if (sbq[d].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out dut%0d edge %0d: got data=%0d, want no output",
                                 d, edge_cnt, dout_w[d]);
                    end else begin
                        e = sbq[d].pop_front();
                        last_out[d] = e.data;
                        if (e.due != edge_cnt || dout_w[d] !== e.data || ovf_w[d] !== e.ovf) begin
                            errors++;
                            $display("FAIL output dut%0d edge %0d: got data=%0d ovf=%b, want data=%0d ovf=%b at edge %0d",
                                     d, edge_cnt, dout_w[d], ovf_w[d], e.data, e.ovf, e.due);
                        end
                    end
                end else if (oval_w[d] === 1'b0) begin
                    checks++;
                    if (dout_w[d] !== last_out[d] || ovf_w[d] !== 1'b0) begin
                        errors++;
                        $display("FAIL idle_hold dut%0d edge %0d: got data=%0d ovf=%b, want data=%0d ovf=0",
                                 d, edge_cnt, dout_w[d], ovf_w[d], last_out[d]);
                    end
                    if (sbq[d].size() > 0 && sbq[d][0].due <= edge_cnt) begin
                        checks++;
                        errors++;
                        e = sbq[d].pop_front();
                        $display("FAIL missing_out dut%0d edge %0d: got out_valid=0, want data=%0d",
                                 d, edge_cnt, e.data);
                    end
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL out_valid_x dut%0d edge %0d: got %b, want 0 or 1", d, edge_cnt, oval_w[d]);
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < NDUT; d++)
            last_out[d] = '0;

        do_reset();
        tick();
        tick();

        // Impulse response with a[k] = k+1.
        load_ramp();
        swap_banks();
        send(1);
        repeat (20) send(0);

        // Same impulse with in_valid gaps.
        send(1);
        repeat (20) begin
            send(0);
            tick();
        end

        // Reset while the impulse is in flight; banks must come back zero.
        send(1);
        repeat (7) send(0);
        do_reset();
        send(1);
        repeat (20) send(0);

        // Flush while the impulse is in flight; banks must be kept.
        load_ramp();
        swap_banks();
        send(1);
        repeat (7) send(0);
        do_flush();
        send(1);
        repeat (20) send(0);

        // Saturation with a[0] = 32767.
        for (int k = 0; k < TAPS; k++)
            wcoef(k, (k == 0) ? 32767 : 0);
        swap_banks();
        do_flush();
        send(32767);
        send(-32768);
        send(1);

        // Rounding with a[0] = 1.
        wcoef(0, 1);
        swap_banks();
        send(3);
        send(-3);

        // Swap on the same edge as a sample, then same-edge write and swap.
        wcoef(0, 2);
        coef_swap = 1'b1;
        send(5);
        send(5);
        coef_swap = 1'b1;
        wcoef(0, 7);
        send(1);
        swap_banks();
        send(1);

        // Out-of-range writes are ignored.
        wcoef(19, 100);
        wcoef(31, -5);
        swap_banks();
        send(1);
        send(0);

        // Randomised traffic.
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 9) < 3) begin
                coef_we   = 1'b1;
                coef_addr = 5'($urandom_range(0, 31));
                coef_data = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                                        : 16'(int'($urandom_range(0, 63)) - 32);
            end
            if ($urandom_range(0, 19) == 0) coef_swap = 1'b1;
            if ($urandom_range(0, 49) == 0) flush = 1'b1;
            if ($urandom_range(0, 249) == 0) reset = 1'b1;
            in_valid = ($urandom_range(0, 3) != 0);
            data_in  = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                                   : 16'(int'($urandom_range(0, 255)) - 128);
            tick();
        end

        repeat (4) tick();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
